approx_adder_pipe: RTL

APPROX_ADDER_PIPE -- requirements
Module: approx_adder_pipe

---
 rtl/approx_adder_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/approx_adder_pipe.sv
// Two-stage pipelined adder with per-beat approximate/exact mode and error statistics.
// Approximate mode zeroes the Z LSBs, ORs the next O bits and adds only the upper bits.
module approx_adder_pipe #(
  parameter int W  = 16,
  parameter int Z  = 2,
  parameter int O  = 6,
  parameter int EW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  i1,
  input  logic [W-1:0]  i2,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  y,
  output logic          cout,
  input  logic          clr_stats,
  output logic [EW-1:0] err_acc,
  output logic [EW-1:0] beat_cnt
);

  localparam int ZO = Z + O;
  localparam int SW = ((EW > W + 1) ? EW : W + 1) + 1;
  localparam logic [W:0]    OR_MASK = ({(W+1){1'b1}} << Z) & ~({(W+1){1'b1}} << ZO);
  localparam logic [EW-1:0] ACC_MAX = '1;

  // S1 keeps both candidate sums; they carry everything S2 needs from the operands.
  typedef struct packed {
    logic       mode;
    logic [W:0] apx;
    logic [W:0] exa;
  } s1_t;

  typedef struct packed {
    logic       mode;
    logic [W:0] sum;
    logic [W:0] err;
  } s2_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  logic [EW-1:0] err_acc_q, err_acc_d;
  logic [EW-1:0] beat_cnt_q, beat_cnt_d;

  logic [W:0] exa_sum, apx_sum, hi_sum, or_bits;
  logic       s1_load, s2_load, out_xfer;
  logic [SW-1:0] acc_sum;

  // Front-end arithmetic on the incoming operands.
  always_comb begin
    exa_sum = {1'b0, i1} + {1'b0, i2};
    hi_sum  = ({1'b0, i1} >> ZO) + ({1'b0, i2} >> ZO);
    or_bits = {1'b0, (i1 | i2)} & OR_MASK;
    apx_sum = (hi_sum << ZO) | or_bits;
  end

  // A stage loads when empty or when its current beat moves on this cycle.
  always_comb begin
    out_xfer = s2_vld_q & out_ready;
    s2_load  = s1_vld_q & (~s2_vld_q | out_ready);
    in_ready = ~rst & (~s1_vld_q | s2_load);
    s1_load  = in_valid & in_ready;
    s1_vld_d = s1_load | (s1_vld_q & ~s2_load);
    s2_vld_d = s2_load | (s2_vld_q & ~out_xfer);
  end

  always_comb begin
    s1_d = s1_q;
    if (s1_load) begin
      s1_d.mode = mode;
      s1_d.apx  = apx_sum;
      s1_d.exa  = exa_sum;
    end
  end

  always_comb begin
    s2_d = s2_q;
    if (s2_load) begin
      s2_d.mode = s1_q.mode;
      s2_d.sum  = s1_q.mode ? s1_q.exa : s1_q.apx;
      s2_d.err  = (s1_q.exa >= s1_q.apx) ? (s1_q.exa - s1_q.apx) : (s1_q.apx - s1_q.exa);
    end
  end

  // Statistics: only approximate beats leaving S2 count; clear overrides.
  always_comb begin
    err_acc_d  = err_acc_q;
    beat_cnt_d = beat_cnt_q;
    acc_sum    = SW'(err_acc_q) + SW'(s2_q.err);
    if (clr_stats) begin
      err_acc_d  = '0;
      beat_cnt_d = '0;
    end else if (out_xfer && !s2_q.mode) begin
      err_acc_d = (acc_sum > SW'(ACC_MAX)) ? ACC_MAX : acc_sum[EW-1:0];
      if (beat_cnt_q != ACC_MAX) beat_cnt_d = beat_cnt_q + EW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      err_acc_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      err_acc_q  <= err_acc_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign out_valid   = s2_vld_q;
  assign {cout, y}   = s2_q.sum;
  assign err_acc     = err_acc_q;
  assign beat_cnt    = beat_cnt_q;

endmodule
